// File: rtl/fir_tap_seq18x25.sv
// Sequencer feeding (sample, coefficient) bursts to the 18x25 MAC; one TAPS-long burst per accepted sample.
// Latency: tap k appears 2+k cycles after acceptance; busy blocks iv (dropped, sets ovr). Option: FIRSEQ_CBANK_EN.
module fir_tap_seq18x25 #(
    parameter int TAPS = 32,
    parameter int AW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [17:0] din,
    input  logic               iv,
    input  logic               cwe,
`ifdef FIRSEQ_CBANK_EN
    input  logic [AW:0]        cwa,
`else
    input  logic [AW-1:0]      cwa,
`endif
    input  logic signed [24:0] cwd,
    input  logic               cbank,
    output logic signed [17:0] dout,
    output logic signed [24:0] cout,
    output logic               first,
    output logic               last,
    output logic               busy,
    output logic               ovr
);

`ifdef FIRSEQ_CBANK_EN
    localparam int CAW = AW + 1;
`else
    localparam int CAW = AW;
`endif

    localparam logic [AW-1:0] KMAX  = AW'(TAPS - 1);
    localparam logic [AW:0]   FFULL = (AW + 1)'(TAPS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [AW-1:0]      wp;
    logic [AW-1:0]      rp;
    logic [AW-1:0]      k;
    logic [AW:0]        fill;
    logic [CAW-1:0]     caddr;
    logic               acc;

    logic signed [17:0] smem [2**AW];
    logic signed [24:0] cmem [2**CAW];

    assign acc = iv & ~busy;

`ifdef FIRSEQ_CBANK_EN
    logic bank;
    assign caddr = {bank, k};
`else
    logic unused_cbank;
    assign unused_cbank = cbank;
    assign caddr        = k;
`endif

    // RAMs carry no reset; stale sample words are hidden by the fill mask.
    always_ff @(posedge clk) begin
        if (cwe)
            cmem[cwa] <= cwd;
        if (acc)
            smem[wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wp    <= '0;
            rp    <= '0;
            k     <= '0;
            fill  <= '0;
            busy  <= 1'b0;
            ovr   <= 1'b0;
            dout  <= '0;
            cout  <= '0;
            first <= 1'b0;
            last  <= 1'b0;
`ifdef FIRSEQ_CBANK_EN
            bank  <= 1'b0;
`endif
        end else begin
            // busy also covers the cycle in which the last tap is on the outputs
            busy <= acc | (state == RUN);
            if (iv && busy)
                ovr <= 1'b1;
            case (state)
                IDLE: begin
                    dout  <= '0;
                    cout  <= '0;
                    first <= 1'b0;
                    last  <= 1'b0;
                    if (acc) begin
                        state <= RUN;
                        rp    <= wp;
                        k     <= '0;
                        if (fill != FFULL)
                            fill <= fill + 1'b1;
`ifdef FIRSEQ_CBANK_EN
                        bank  <= cbank;
`endif
                    end
                end
                RUN: begin
                    dout  <= ({1'b0, k} < fill) ? smem[rp] : '0;
                    cout  <= cmem[caddr];
                    first <= (k == '0);
                    last  <= (k == KMAX);
                    rp    <= rp - 1'b1;
                    k     <= k + 1'b1;
                    if (k == KMAX) begin
                        state <= IDLE;
                        wp    <= wp + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tap_seq18x25.sv
// Randomized bench for fir_tap_seq18x25 against a sample-history/coefficient-array reference model.
module tb_fir_tap_seq18x25;
    localparam int TAPS = 4;
    localparam int AW   = 3;
`ifdef FIRSEQ_CBANK_EN
    localparam int CAW = AW + 1;
`else
    localparam int CAW = AW;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [17:0] din = '0;
    logic               iv = 1'b0;
    logic               cwe = 1'b0;
    logic [CAW-1:0]     cwa = '0;
    logic signed [24:0] cwd = '0;
    logic               cbank = 1'b0;
    logic signed [17:0] dout;
    logic signed [24:0] cout;
    logic               first, last, busy, ovr;

    int checks = 0;
    int errors = 0;
    int bank_flip_at = -1;

    logic signed [17:0] hist [$];
    logic signed [24:0] coef_m [2**CAW];

    always #5 clk = ~clk;

    fir_tap_seq18x25 #(.TAPS(TAPS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .din(din), .iv(iv), .cwe(cwe), .cwa(cwa), .cwd(cwd),
        .cbank(cbank), .dout(dout), .cout(cout), .first(first), .last(last),
        .busy(busy), .ovr(ovr)
    );

    // Called at a negedge; leaves the bench at the following negedge.
    task automatic write_coef(input logic [CAW-1:0] a, input logic signed [24:0] v);
        cwe = 1'b1; cwa = a; cwd = v;
        coef_m[a] = v;
        @(negedge clk);
        cwe = 1'b0;
    endtask

    // Called at a negedge with busy low. drop_at: pulse iv during tap index; wr_at: coefficient
    // write landing in the same cycle the DUT reads coef[wr_at].
    task automatic run_burst(input logic signed [17:0] s, input int drop_at, input int wr_at,
                             input logic signed [24:0] wr_val);
        logic signed [17:0] exp_d [TAPS];
        logic signed [24:0] exp_c [TAPS];
        int base;
        din = s; iv = 1'b1;
        hist.push_front(s);
        if (hist.size() > TAPS) hist.delete(hist.size() - 1);
        base = 0;
`ifdef FIRSEQ_CBANK_EN
        base = cbank ? (2**AW) : 0;
`endif
        for (int i = 0; i < TAPS; i++) begin
            exp_d[i] = (i < hist.size()) ? hist[i] : 18'sd0;
            exp_c[i] = coef_m[base + i];
        end
        @(negedge clk);
        iv = 1'b0;
        checks++;
        if (busy !== 1'b1 || dout !== 18'sd0 || first !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL accept_cycle: busy=%b dout=%0d first=%b last=%b, required busy=1 dout=0 first=0 last=0",
                     busy, dout, first, last);
        end
        if (wr_at == 0) begin
            cwe = 1'b1; cwa = CAW'(base); cwd = wr_val; coef_m[base] = wr_val;
        end
        for (int k = 0; k < TAPS; k++) begin
            @(negedge clk);
            iv = 1'b0; cwe = 1'b0;
            checks++;
            if (dout !== exp_d[k] || cout !== exp_c[k] || first !== (k == 0) ||
                last !== (k == TAPS - 1) || busy !== 1'b1) begin
                errors++;
                $display("FAIL tap%0d: dout=%0d cout=%0d first=%b last=%b busy=%b, required dout=%0d cout=%0d first=%b last=%b busy=1",
                         k, dout, cout, first, last, busy, exp_d[k], exp_c[k], k == 0, k == TAPS - 1);
            end
            if (k == drop_at) begin
                iv = 1'b1; din = 18'($urandom());
            end
            if (k == wr_at - 1) begin
                cwe = 1'b1; cwa = CAW'(base + wr_at); cwd = wr_val; coef_m[base + wr_at] = wr_val;
            end
            if (k == bank_flip_at) cbank = ~cbank;
        end
        @(negedge clk);
        iv = 1'b0; cwe = 1'b0;
        checks++;
        if (busy !== 1'b0 || dout !== 18'sd0 || cout !== 25'sd0 || first !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL burst_end: busy=%b dout=%0d cout=%0d first=%b last=%b, required all 0",
                     busy, dout, cout, first, last);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dout, cout, first, last, busy, ovr} !== '0) begin
            errors++;
            $display("FAIL reset_async: dout=%0d cout=%0d first=%b last=%b busy=%b ovr=%b, required all 0",
                     dout, cout, first, last, busy, ovr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hist.delete();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ovr !== 1'b0 || dout !== 18'sd0) begin
            errors++;
            $display("FAIL reset_release: busy=%b ovr=%b dout=%0d, required 0 0 0", busy, ovr, dout);
        end
    endtask

    task automatic test_impulse();
        for (int i = 0; i < TAPS; i++) write_coef(CAW'(i), 25'(i + 1));
        run_burst(18'sd100, -1, -1, '0);
        for (int i = 0; i < 3; i++) run_burst(18'sd0, -1, -1, '0);
    endtask

    task automatic test_overrun();
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear: ovr=%b, required 0", ovr);
        end
        run_burst(18'($urandom()), 1, -1, '0);
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set: ovr=%b, required 1", ovr);
        end
        run_burst(18'($urandom()), -1, -1, '0);
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL ovr_sticky: ovr=%b, required 1", ovr);
        end
    endtask

    task automatic test_coef_hazard();
        run_burst(18'($urandom()), -1, 2, 25'($urandom()));
        run_burst(18'($urandom()), -1, 0, 25'($urandom()));
        run_burst(18'($urandom()), -1, -1, '0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < TAPS; i++) write_coef(CAW'(i), 25'($urandom()));
        for (int b = 0; b < 12; b++) begin
            int gap;
            run_burst(18'($urandom()), -1, -1, '0);
            gap = (b % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || dout !== 18'sd0 || cout !== 25'sd0 || first !== 1'b0 || last !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_outputs: busy=%b dout=%0d cout=%0d first=%b last=%b, required all 0",
                             busy, dout, cout, first, last);
                end
            end
        end
    endtask

    task automatic test_midburst_reset();
        din = 18'sd777; iv = 1'b1;
        @(negedge clk);
        iv = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dout !== hist[1] || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_tap2: dout=%0d busy=%b, required dout=%0d busy=1", dout, busy, hist[1]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dout !== 18'sd0 || cout !== 25'sd0 || busy !== 1'b0 || first !== 1'b0 || last !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset: dout=%0d cout=%0d busy=%b first=%b last=%b, required all 0",
                     dout, cout, busy, first, last);
        end
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        run_burst(18'($urandom()), -1, -1, '0);
        run_burst(18'($urandom()), -1, -1, '0);
    endtask

`ifdef FIRSEQ_CBANK_EN
    task automatic test_bank();
        for (int i = 0; i < TAPS; i++) begin
            write_coef(CAW'(i), 25'sd1);
            write_coef(CAW'((2**AW) + i), 25'sd2);
        end
        cbank = 1'b0;
        bank_flip_at = 1;
        run_burst(18'($urandom()), -1, -1, '0);
        bank_flip_at = -1;
        run_burst(18'($urandom()), -1, -1, '0);
        write_coef(CAW'(1), 25'sd9);
        run_burst(18'($urandom()), -1, -1, '0);
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_overrun();
        test_coef_hazard();
        test_back_to_back();
        test_midburst_reset();
`ifdef FIRSEQ_CBANK_EN
        test_bank();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_tap_seq18x25.md
# fir_tap_seq18x25

Upstream sequencer for the 18×25 pipelined multiplier-accumulator. On each accepted input sample it stores the sample in a circular delay line and replays one burst of `TAPS` (sample, coefficient) pairs, newest sample first. Each burst is tagged with `first` and `last` so the downstream accumulator produces one filtered output per input sample. Coefficients are held in an internal RAM that the host loads over a simple write port.

## Interface
- `TAPS`, 32: filter length; 2 ≤ `TAPS` ≤ 2^`AW`.
- `AW`, 5: address width of the sample and coefficient RAMs.
- `clk`  in  1  master clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  18  signed input sample.
- `iv`  in  1  input valid; one-cycle strobe.
- `cwe`  in  1  coefficient write enable.
- `cwa`  in  `AW` (+1 with bank macro)  coefficient write address; MSB is the bank when the macro is defined.
- `cwd`  in  25  signed coefficient write data.
- `cbank`  in  1  coefficient bank select; used only with the bank macro.
- `dout`  out  18  sample to the MAC data input.
- `cout`  out  25  coefficient to the MAC coefficient input.
- `first`  out  1  marks tap 0 of a burst.
- `last`  out  1  marks tap `TAPS`-1 of a burst.
- `busy`  out  1  burst in progress; `iv` is not accepted while high.
- `ovr`  out  1  sticky overrun flag.

## Operation
- **States**
  - IDLE → RUN when `iv`=1 and `busy`=0. In that same cycle `din` is written at write pointer `wp`, read pointer `rp` is loaded with `wp`, and tap counter `k` is set to 0.
  - RUN: each cycle read sample[`rp`] and coef[`k`]; then `rp` ← `rp`−1 (mod 2^`AW`) and `k` ← `k`+1.
  - After `k`=`TAPS`-1 the state returns to IDLE and `wp` ← `wp`+1 (mod 2^`AW`).
- **Tap mapping:** tap k pairs sample x[n−k] with coefficient c[k].
- **Fill counter:** `fill` counts samples accepted since reset and saturates at `TAPS`. For any tap k ≥ `fill`, `dout` is forced to 0, so stale RAM contents never reach the MAC.
- **Idle outputs:** when no tap is being presented, `dout`=0, `cout`=0, `first`=0, `last`=0.
- **Overrun:** `iv`=1 while `busy`=1 drops the sample and sets `ovr`. Only `rst` clears `ovr`.
- **Coefficient writes** are allowed at any time. If a write and a read hit the same address in the same cycle, the read returns the old value.
- **RAMs** have no reset; `rst` clears state, pointers, `fill`, `ovr` and all output registers.
- **Reset values:** `dout`=0, `cout`=0, `first`=0, `last`=0, `busy`=0, `ovr`=0.

## Timing
- `iv` accepted at edge n:
  - `busy` is high from n+1 through n+`TAPS`+1 inclusive.
  - Tap k appears on the outputs in cycle n+2+k (synchronous RAM read plus registered outputs).
  - `first` is high in cycle n+2 only; `last` is high in cycle n+`TAPS`+1 only.
- **Sample rate:** the earliest next acceptance is edge n+`TAPS`+2, so the minimum sample period is `TAPS`+2 clocks. `iv` in the cycle `busy` falls is accepted.
- **Reset mid-burst:** outputs go to 0 immediately (asynchronous). The burst is abandoned, and the MAC sees no `last` for it.
- **Pointer wrap:** `rp` wraps from 0 to 2^`AW`−1 without a gap cycle.

## Configuration
- **`FIRSEQ_CBANK_EN` defined:**
  - The coefficient RAM holds two banks, 2^(`AW`+1) words; the `cwa` MSB selects the bank to write.
  - `cbank` is sampled only at the IDLE→RUN transition and held for the whole burst, so a bank swap never splits a burst.
  - Writes to the inactive bank are hazard-free.
- **Not defined:** a single bank of 2^`AW` words; `cbank` is ignored and `cwa` is `AW` bits wide.

## Test plan
- **Reset:** assert `rst` asynchronously with no clock → all outputs 0 immediately; after release `busy`=0 and `ovr`=0.
- **Impulse, `TAPS`=4:** load c = {1,2,3,4}; send samples 100, 0, 0, 0, each spaced 6 clocks.
  - Required: burst 1 `dout` = 100, 0, 0, 0 (fill masking) with `cout` = 1, 2, 3, 4.
  - Required: burst 4 `dout` = 0, 0, 0, 100.
  - `first`/`last` land at n+2 and n+5.
- **Overrun:** `iv` at n and again at n+3 with `TAPS`=4 → second sample dropped, `ovr`=1 and stays 1; the next `iv` at n+6 is accepted.
- **Wrap:** `AW`=3, `TAPS`=8, 20 consecutive samples 1..20 → burst for sample 20 gives `dout` = 20, 19, …, 13 with no gaps.
- **Mid-burst reset:** assert `rst` at tap 2 → `dout`=0, `busy`=0 and `first`/`last` low immediately. The next sample after release behaves as the first sample after power-up (fill masking active).
- **Bank swap (`FIRSEQ_CBANK_EN`):** bank 0 = all 1, bank 1 = all 2; toggle `cbank` during a burst → that burst keeps its bank; the next burst uses the new bank.
